// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan speed controller.
// Holds the fixed datapath widths, the full-scale duty value, the widths of
// the signed error/sum arithmetic and the controller state encoding.
package fan_ctrl_pkg;

    // Duty width must match the PWM counter width of the fan PWM/tach stage.
    localparam int DUTY_W   = 10;
    localparam int RPM_W    = 16;
    localparam int DUTY_MAX = (2 ** DUTY_W) - 1;

    // err = target - rpm needs one extra bit for the sign; the sum of duty
    // and step needs one more so the clamp sees overflow in either direction.
    localparam int ERR_W = RPM_W + 1;
    localparam int SUM_W = RPM_W + 2;

    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(DUTY_MAX);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_KICK  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } fan_state_t;

endpackage

// File: rtl/fan_step_calc.sv
// Combinational integral step for the fan regulator.
// Computes err = target_rpm - rpm, step = err >>> STEP_SHIFT with a minimum
// magnitude of one count whenever err is non-zero, and returns duty + step
// clamped to [MIN_DUTY, DUTY_MAX].
// Ports:
//   duty       - current registered duty
//   rpm        - measured tach count for this window
//   target_rpm - desired tach count per window
//   next_duty  - clamped duty to load on this sample
module fan_step_calc
    import fan_ctrl_pkg::*;
#(
    parameter int MIN_DUTY   = 128,
    parameter int STEP_SHIFT = 4
) (
    input  logic [DUTY_W-1:0] duty,
    input  logic [RPM_W-1:0]  rpm,
    input  logic [RPM_W-1:0]  target_rpm,
    output logic [DUTY_W-1:0] next_duty
);

    localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(MIN_DUTY);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(DUTY_MAX);

    logic signed [ERR_W-1:0] err_s;
    logic signed [ERR_W-1:0] shift_s;
    logic signed [ERR_W-1:0] step_s;
    logic signed [SUM_W-1:0] sum_s;

    // Error, floored shift, minimum-step correction, sum and clamp.
    always_comb begin
        err_s   = $signed({1'b0, target_rpm}) - $signed({1'b0, rpm});
        shift_s = err_s >>> STEP_SHIFT;
        // Small errors would otherwise shift to zero and the loop would never
        // settle on the last few counts; force a single-count nudge instead.
        if ((shift_s == {ERR_W{1'b0}}) && (err_s != {ERR_W{1'b0}})) begin
            if (err_s[ERR_W-1]) begin
                step_s = {ERR_W{1'b1}};
            end else begin
                step_s = {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            step_s = shift_s;
        end
        sum_s = $signed({{(SUM_W-DUTY_W){1'b0}}, duty})
              + $signed({{(SUM_W-ERR_W){step_s[ERR_W-1]}}, step_s});
        if (sum_s < MIN_S) begin
            next_duty = DUTY_W'(MIN_DUTY);
        end else if (sum_s > MAX_S) begin
            next_duty = DUTY_FULL;
        end else begin
            next_duty = sum_s[DUTY_W-1:0];
        end
    end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Closed-loop fan controller producing the PWM duty (fan_speed) for the fan
// PWM/tach stage. Handles kick-start at full duty, integral regulation on
// each tach sample, stall detection into a sticky full-speed fault and a
// manual duty override.
// Ports:
//   host_clk, reset - clock and asynchronous active-high reset
//   enable          - level, 0 forces OFF
//   manual_mode     - level, 1 drives manual_duty and bypasses regulation
//   manual_duty     - duty used while manual_mode is high
//   target_rpm      - desired tach count per window, 0 turns the fan off
//   rpm_valid, rpm  - single-cycle tach sample strobe and its count
//   duty            - registered PWM duty
//   stalled         - registered, high while in FAULT
//   busy            - registered, high in KICK or RUN
module fan_speed_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int MIN_DUTY      = 128,
    parameter int START_DUTY    = 512,
    parameter int KICK_WINDOWS  = 2,
    parameter int STALL_WINDOWS = 3,
    parameter int STEP_SHIFT    = 4
) (
    input  logic              host_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              manual_mode,
    input  logic [DUTY_W-1:0] manual_duty,
    input  logic [RPM_W-1:0]  target_rpm,
    input  logic              rpm_valid,
    input  logic [RPM_W-1:0]  rpm,
    output logic [DUTY_W-1:0] duty,
    output logic              stalled,
    output logic              busy
);

    localparam int KICK_CNT_W  = $clog2(KICK_WINDOWS + 1);
    localparam int STALL_CNT_W = $clog2(STALL_WINDOWS + 1);

    fan_state_t             state_r;
    logic [DUTY_W-1:0]      duty_r;
    logic                   stalled_r;
    logic                   busy_r;
    logic [KICK_CNT_W-1:0]  kick_cnt_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic [DUTY_W-1:0]      next_duty_s;
    logic                   tgt_zero_s;

    assign tgt_zero_s = (target_rpm == {RPM_W{1'b0}});

    fan_step_calc #(
        .MIN_DUTY   (MIN_DUTY),
        .STEP_SHIFT (STEP_SHIFT)
    ) u_step (
        .duty       (duty_r),
        .rpm        (rpm),
        .target_rpm (target_rpm),
        .next_duty  (next_duty_s)
    );

    // Controller FSM; outputs are loaded from the next state on the same edge.
    always_ff @(posedge host_clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_OFF;
            duty_r      <= {DUTY_W{1'b0}};
            stalled_r   <= 1'b0;
            busy_r      <= 1'b0;
            kick_cnt_r  <= {KICK_CNT_W{1'b0}};
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (manual_mode) begin
            state_r     <= ST_OFF;
            duty_r      <= manual_duty;
            stalled_r   <= 1'b0;
            busy_r      <= 1'b0;
            kick_cnt_r  <= {KICK_CNT_W{1'b0}};
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (!enable) begin
            state_r     <= ST_OFF;
            duty_r      <= {DUTY_W{1'b0}};
            stalled_r   <= 1'b0;
            busy_r      <= 1'b0;
            kick_cnt_r  <= {KICK_CNT_W{1'b0}};
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_OFF: begin
                    stalled_r   <= 1'b0;
                    kick_cnt_r  <= {KICK_CNT_W{1'b0}};
                    stall_cnt_r <= {STALL_CNT_W{1'b0}};
                    if (!tgt_zero_s) begin
                        state_r <= ST_KICK;
                        duty_r  <= DUTY_FULL;
                        busy_r  <= 1'b1;
                    end else begin
                        duty_r  <= {DUTY_W{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                ST_KICK: begin
                    stalled_r   <= 1'b0;
                    stall_cnt_r <= {STALL_CNT_W{1'b0}};
                    // Turning off takes precedence over a sample on the same cycle.
                    if (tgt_zero_s) begin
                        state_r    <= ST_OFF;
                        duty_r     <= {DUTY_W{1'b0}};
                        busy_r     <= 1'b0;
                        kick_cnt_r <= {KICK_CNT_W{1'b0}};
                    end else if (rpm_valid && (kick_cnt_r == KICK_CNT_W'(KICK_WINDOWS - 1))) begin
                        state_r    <= ST_RUN;
                        duty_r     <= DUTY_W'(START_DUTY);
                        busy_r     <= 1'b1;
                        kick_cnt_r <= KICK_CNT_W'(KICK_WINDOWS);
                    end else begin
                        duty_r <= DUTY_FULL;
                        busy_r <= 1'b1;
                        if (rpm_valid && (kick_cnt_r != KICK_CNT_W'(KICK_WINDOWS))) begin
                            kick_cnt_r <= kick_cnt_r + KICK_CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (tgt_zero_s) begin
                        state_r     <= ST_OFF;
                        duty_r      <= {DUTY_W{1'b0}};
                        stalled_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        stall_cnt_r <= {STALL_CNT_W{1'b0}};
                    end else if (rpm_valid && (rpm == {RPM_W{1'b0}})
                                 && (stall_cnt_r == STALL_CNT_W'(STALL_WINDOWS - 1))) begin
                        state_r     <= ST_FAULT;
                        duty_r      <= DUTY_FULL;
                        stalled_r   <= 1'b1;
                        busy_r      <= 1'b0;
                        stall_cnt_r <= STALL_CNT_W'(STALL_WINDOWS);
                    end else if (rpm_valid) begin
                        duty_r    <= next_duty_s;
                        stalled_r <= 1'b0;
                        busy_r    <= 1'b1;
                        if (rpm != {RPM_W{1'b0}}) begin
                            stall_cnt_r <= {STALL_CNT_W{1'b0}};
                        end else if (stall_cnt_r != STALL_CNT_W'(STALL_WINDOWS)) begin
                            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
                        end
                    end else begin
                        stalled_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Sticky: only manual_mode, !enable or reset leave FAULT.
                    duty_r    <= DUTY_FULL;
                    stalled_r <= 1'b1;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r     <= ST_OFF;
                    duty_r      <= {DUTY_W{1'b0}};
                    stalled_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    kick_cnt_r  <= {KICK_CNT_W{1'b0}};
                    stall_cnt_r <= {STALL_CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign duty    = duty_r;
    assign stalled = stalled_r;
    assign busy    = busy_r;

endmodule
